// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - Signal bundle between dcache_ctrl and the CPU port, cache arrays and memory
interface dcache_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 5
);
    localparam int TAG_W = ADDR_W - INDEX_W - 4;

    logic               cpu_req_valid;
    logic               cpu_req_ready;
    logic               cpu_wr;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [31:0]        cpu_wdata;
    logic [3:0]         cpu_wstrb;
    logic               cpu_resp_valid;
    logic [31:0]        cpu_rdata;

    logic [INDEX_W-1:0] arr_index;
    logic [1:0]         arr_word;
    logic [1:0]         valid;
    logic [1:0]         tag_hit;
    logic [63:0]        way_rdata;
    logic               valid_write;
    logic               way_sel;
    logic               tag_we;
    logic [TAG_W-1:0]   tag_wdata;
    logic               data_we;
    logic [3:0]         data_wstrb;
    logic [31:0]        data_wdata;

    logic               mem_rreq;
    logic [ADDR_W-1:0]  mem_raddr;
    logic               mem_rgnt;
    logic               mem_rvalid;
    logic [31:0]        mem_rdata;
    logic               mem_wreq;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_wstrb;
    logic               mem_wgnt;

    modport master (
        input  cpu_req_valid, cpu_wr, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_req_ready, cpu_resp_valid, cpu_rdata,
        input  valid, tag_hit, way_rdata,
        output arr_index, arr_word, valid_write, way_sel, tag_we, tag_wdata,
        output data_we, data_wstrb, data_wdata,
        input  mem_rgnt, mem_rvalid, mem_rdata, mem_wgnt,
        output mem_rreq, mem_raddr, mem_wreq, mem_waddr, mem_wdata, mem_wstrb
    );

    modport slave (
        output cpu_req_valid, cpu_wr, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
        output valid, tag_hit, way_rdata,
        input  arr_index, arr_word, valid_write, way_sel, tag_we, tag_wdata,
        input  data_we, data_wstrb, data_wdata,
        output mem_rgnt, mem_rvalid, mem_rdata, mem_wgnt,
        input  mem_rreq, mem_raddr, mem_wreq, mem_waddr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - Hit/miss control FSM for a 2-way, 32-set write-through data cache
module dcache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 5
) (
    input  logic          clk,
    input  logic          rstn,
    dcache_ctrl_if.master bus
);
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, WRITE, RESP} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [SETS-1:0]     lru_q, lru_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                victim_q, victim_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [INDEX_W-1:0]  idx;
    logic [1:0]          hitv;
    logic                hit;
    logic                hit_way;

    assign idx     = addr_q[INDEX_W+3:4];
    assign hitv    = bus.valid & bus.tag_hit;
    assign hit     = |hitv;
    // A double hit should never happen; way 0 takes precedence if it does.
    assign hit_way = ~hitv[0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            lru_q    <= '0;
            cnt_q    <= '0;
            victim_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            lru_q    <= lru_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        wr_d               = wr_q;
        wdata_d            = wdata_q;
        wstrb_d            = wstrb_q;
        lru_d              = lru_q;
        cnt_d              = cnt_q;
        victim_d           = victim_q;
        rdata_d            = rdata_q;
        bus.cpu_req_ready  = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        bus.cpu_rdata      = '0;
        bus.valid_write    = 1'b0;
        bus.way_sel        = 1'b0;
        bus.tag_we         = 1'b0;
        bus.data_we        = 1'b0;
        bus.data_wstrb     = '0;
        bus.data_wdata     = '0;
        bus.mem_rreq       = 1'b0;
        bus.mem_wreq       = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_valid) begin
                    addr_d  = bus.cpu_addr;
                    wr_d    = bus.cpu_wr;
                    wdata_d = bus.cpu_wdata;
                    wstrb_d = bus.cpu_wstrb;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) lru_d[idx] = ~hit_way;
                if (!wr_q) begin
                    if (hit) begin
                        bus.cpu_resp_valid = 1'b1;
                        bus.cpu_rdata      = hit_way ? bus.way_rdata[63:32] : bus.way_rdata[31:0];
                        state_d            = IDLE;
                    end else begin
                        // Fill an empty way first; only evict when the set is full.
                        victim_d = !bus.valid[0] ? 1'b0 : (!bus.valid[1] ? 1'b1 : lru_q[idx]);
                        state_d  = MISS;
                    end
                end else begin
                    if (hit) begin
                        bus.data_we    = 1'b1;
                        bus.way_sel    = hit_way;
                        bus.data_wstrb = wstrb_q;
                        bus.data_wdata = wdata_q;
                    end
                    state_d = WRITE;
                end
            end
            MISS: begin
                bus.mem_rreq = 1'b1;
                if (bus.mem_rgnt) begin
                    cnt_d   = 2'd0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_rvalid) begin
                    bus.data_we    = 1'b1;
                    bus.way_sel    = victim_q;
                    bus.data_wstrb = 4'hF;
                    bus.data_wdata = bus.mem_rdata;
                    if (cnt_q == addr_q[3:2]) rdata_d = bus.mem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    // Tag and valid go in with the last beat so a partial line never looks valid.
                    if (cnt_q == 2'd3) begin
                        bus.tag_we      = 1'b1;
                        bus.valid_write = 1'b1;
                        lru_d[idx]      = ~victim_q;
                        state_d         = RESP;
                    end
                end
            end
            WRITE: begin
                bus.mem_wreq = 1'b1;
                if (bus.mem_wgnt) state_d = RESP;
            end
            RESP: begin
                bus.cpu_resp_valid = 1'b1;
                bus.cpu_rdata      = wr_q ? 32'h0 : rdata_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.arr_index = idx;
    assign bus.arr_word  = (state_q == REFILL) ? cnt_q : addr_q[3:2];
    assign bus.tag_wdata = addr_q[ADDR_W-1:INDEX_W+4];
    assign bus.mem_raddr = addr_q & ~ADDR_W'(15);
    assign bus.mem_waddr = addr_q & ~ADDR_W'(3);
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
endmodule
